// File: rtl/fetch_decode_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pipe_pkg
//  Shared definitions for the IF->ID pipeline register:
//    INSTR_W_DEF    default instruction width
//    PC_W_DEF       default PC / PC+4 width
//    NOP_INSTR_DEF  canonical bubble instruction (addi x0,x0,0)
//    stage_state_t  occupancy state of the stage register
// ---------------------------------------------------------------------------
package riscv_pipe_pkg;

   localparam int unsigned INSTR_W_DEF   = 32;
   localparam int unsigned PC_W_DEF      = 8;
   localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

   // EMPTY: nothing for decode; BUSY: main slot valid; FULL: main + skid valid
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } stage_state_t;

endpackage : riscv_pipe_pkg

// File: rtl/fetch_decode_stage_reg_if.sv
// ---------------------------------------------------------------------------
// fetch_decode_stage_reg_if
//  Valid/ready handshake bundle carrying one fetched instruction.
//    valid     producer has an entry
//    ready     consumer can take it (valid & ready = transfer)
//    instr     instruction word          (INSTR_W)
//    pc        PC of instr               (PC_W)
//    pc_plus4  PC+4 of instr             (PC_W)
//  Modports: master drives the payload, slave returns ready.
// ---------------------------------------------------------------------------
interface fetch_decode_stage_reg_if #(
   parameter int unsigned INSTR_W = 32,
   parameter int unsigned PC_W    = 8
) ();

   logic               valid;
   logic               ready;
   logic [INSTR_W-1:0] instr;
   logic [PC_W-1:0]    pc;
   logic [PC_W-1:0]    pc_plus4;

   modport master (
      output valid,
      output instr,
      output pc,
      output pc_plus4,
      input  ready
   );

   modport slave (
      input  valid,
      input  instr,
      input  pc,
      input  pc_plus4,
      output ready
   );

endinterface : fetch_decode_stage_reg_if

// File: rtl/fetch_decode_stage_reg_slot.sv
// ---------------------------------------------------------------------------
// pipe_payload_slot
//  One {instr, pc, pc_plus4} holding register.
//    clk, rst_n     clock, asynchronous active-low reset (-> NOP/0/0)
//    flush          synchronous squash to NOP/0/0, wins over load
//    load           capture d_* on the next rising edge
//    d_*            payload to capture
//    q_*            registered payload
// ---------------------------------------------------------------------------
module pipe_payload_slot
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned        INSTR_W   = INSTR_W_DEF,
   parameter int unsigned        PC_W      = PC_W_DEF,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               flush,
   input  logic               load,
   input  logic [INSTR_W-1:0] d_instr,
   input  logic [PC_W-1:0]    d_pc,
   input  logic [PC_W-1:0]    d_pc_plus4,
   output logic [INSTR_W-1:0] q_instr,
   output logic [PC_W-1:0]    q_pc,
   output logic [PC_W-1:0]    q_pc_plus4
);

   // Payload register: reset/flush insert a bubble, otherwise hold unless loaded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_instr    <= NOP_INSTR;
         q_pc       <= '0;
         q_pc_plus4 <= '0;
      end else if (flush) begin
         q_instr    <= NOP_INSTR;
         q_pc       <= '0;
         q_pc_plus4 <= '0;
      end else if (load) begin
         q_instr    <= d_instr;
         q_pc       <= d_pc;
         q_pc_plus4 <= d_pc_plus4;
      end
   end

endmodule : pipe_payload_slot

// File: rtl/fetch_decode_stage_reg.sv
// ---------------------------------------------------------------------------
// fetch_decode_stage_reg
//  IF->ID pipeline register with valid/ready handshake and NOP-bubble flush.
//    clk      rising-edge clock
//    rst_n    asynchronous active-low reset
//    flush    synchronous squash from the hazard unit
//    in_bus   slave side, from fetch  (in_valid/in_ready/in_instr/in_pc/in_pc_plus4)
//    out_bus  master side, to decode  (out_valid/out_ready/out_instr/out_pc/out_pc_plus4)
//  Build option SKID_BUFFER_EN:
//    defined   : main + skid slot, in_ready derived from state register only
//    undefined : single slot, in_ready = !out_valid | out_ready
// ---------------------------------------------------------------------------
module fetch_decode_stage_reg
   import riscv_pipe_pkg::*;
#(
   parameter int unsigned        INSTR_W   = INSTR_W_DEF,
   parameter int unsigned        PC_W      = PC_W_DEF,
   parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     flush,
   fetch_decode_stage_reg_if.slave  in_bus,
   fetch_decode_stage_reg_if.master out_bus
);

   stage_state_t       state_q;
   stage_state_t       state_d;
   logic               out_valid;
   logic               in_ready;
   logic               accept;
   logic               consume;
   logic               load_main;
   logic               load_skid;

   logic [INSTR_W-1:0] main_d_instr;
   logic [PC_W-1:0]    main_d_pc;
   logic [PC_W-1:0]    main_d_pc_plus4;
   logic [INSTR_W-1:0] main_q_instr;
   logic [PC_W-1:0]    main_q_pc;
   logic [PC_W-1:0]    main_q_pc_plus4;

   // Handshake qualifiers
   assign out_valid = (state_q != EMPTY);
   assign accept    = in_bus.valid & in_ready;
   assign consume   = out_valid & out_bus.ready;

`ifdef SKID_BUFFER_EN
   logic [INSTR_W-1:0] skid_q_instr;
   logic [PC_W-1:0]    skid_q_pc;
   logic [PC_W-1:0]    skid_q_pc_plus4;

   // Ready is a decode of the state register only; the skid slot absorbs the
   // one entry that may arrive while decode is stalling.
   assign in_ready = rst_n & (state_q != FULL);

   // Main refills from the skid slot when draining FULL, else from fetch
   always_comb begin
      main_d_instr    = in_bus.instr;
      main_d_pc       = in_bus.pc;
      main_d_pc_plus4 = in_bus.pc_plus4;
      if (state_q == FULL) begin
         main_d_instr    = skid_q_instr;
         main_d_pc       = skid_q_pc;
         main_d_pc_plus4 = skid_q_pc_plus4;
      end
   end

   pipe_payload_slot #(
      .INSTR_W   (INSTR_W),
      .PC_W      (PC_W),
      .NOP_INSTR (NOP_INSTR)
   ) u_skid_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .load       (load_skid),
      .d_instr    (in_bus.instr),
      .d_pc       (in_bus.pc),
      .d_pc_plus4 (in_bus.pc_plus4),
      .q_instr    (skid_q_instr),
      .q_pc       (skid_q_pc),
      .q_pc_plus4 (skid_q_pc_plus4)
   );
`else
   // Single slot: can take a new entry whenever the current one leaves this cycle
   assign in_ready = rst_n & (~out_valid | out_bus.ready);

   always_comb begin
      main_d_instr    = in_bus.instr;
      main_d_pc       = in_bus.pc;
      main_d_pc_plus4 = in_bus.pc_plus4;
   end
`endif

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state and slot load control; flush overrides everything
   always_comb begin
      state_d   = state_q;
      load_main = 1'b0;
      load_skid = 1'b0;
      if (flush) begin
         state_d = EMPTY;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_d   = BUSY;
                  load_main = 1'b1;
               end
            end
            BUSY: begin
               if (accept && consume) begin
                  load_main = 1'b1;
               end else if (accept) begin
`ifdef SKID_BUFFER_EN
                  state_d   = FULL;
                  load_skid = 1'b1;
`else
                  // Not reachable: without a skid slot, accept implies consume
                  state_d   = BUSY;
`endif
               end else if (consume) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
`ifdef SKID_BUFFER_EN
               if (consume) begin
                  state_d   = BUSY;
                  load_main = 1'b1;
               end
`else
               state_d = EMPTY;
`endif
            end
            default: begin
               state_d = EMPTY;
            end
         endcase
      end
   end

   pipe_payload_slot #(
      .INSTR_W   (INSTR_W),
      .PC_W      (PC_W),
      .NOP_INSTR (NOP_INSTR)
   ) u_main_slot (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .load       (load_main),
      .d_instr    (main_d_instr),
      .d_pc       (main_d_pc),
      .d_pc_plus4 (main_d_pc_plus4),
      .q_instr    (main_q_instr),
      .q_pc       (main_q_pc),
      .q_pc_plus4 (main_q_pc_plus4)
   );

   // Bus outputs
   assign in_bus.ready      = in_ready;
   assign out_bus.valid     = out_valid;
   assign out_bus.instr     = main_q_instr;
   assign out_bus.pc        = main_q_pc;
   assign out_bus.pc_plus4  = main_q_pc_plus4;

endmodule : fetch_decode_stage_reg
